collision_tracker: RTL
======================

# collision_tracker

Parametrised collision and health tracker for the game datapath. It watches N enemy y-positions against the player's hit line and detects each crossing exactly once per enemy approach. It keeps the player's health and applies an invulnerability cooldown after every hit. It drives the game-over flag consumed by the top-level game FSM and display logic.

## Interface
Parameters:
- N_ENEMY, 3, number of enemy channels
- Y_W, 8, width of each enemy y coordinate
- HIT_Y, 119, y coordinate of the player hit line
- MAX_HEALTH, 3, health loaded on start (1..2^HP_W-1)
- HP_W, 4, width of health counter
- COOLDOWN, 16, invulnerability length in clk cycles after a hit (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  level; begins/restarts a game from IDLE or OVER
- enemy_y  in  N_ENEMY*Y_W  packed y positions; enemy k at bits [k*Y_W +: Y_W]
- enemy_valid  in  N_ENEMY  enemy k is alive/on screen
- hit_pulse  out  1  one-cycle pulse per damaging hit
- hit_mask  out  N_ENEMY  enemies that caused the current hit_pulse; valid with hit_pulse, else 0
- health  out  HP_W  current health
- invuln  out  1  high while cooldown runs
- game_over  out  1  high in OVER state

## Operation
- States: IDLE, PLAY, INVULN, OVER. Reset → IDLE, health=0, all outputs 0, cooldown counter 0, all armed bits 1.
- Per-enemy match: match[k] = enemy_valid[k] && enemy_y[k]==HIT_Y (see Configuration).
- Per-enemy armed[k]: clears on the cycle match[k] is seen while armed, in any state. It sets again when match[k] is low. An enemy parked on the line therefore hits once only.
- new_hit[k] = match[k] && armed[k].
- IDLE: start=1 → PLAY, health←MAX_HEALTH, armed←all 1.
- PLAY: if any new_hit, the following happens on the same edge:
  - hit_pulse←1 and hit_mask←new_hit.
  - health←health-1. Simultaneous hits count as one damage.
  - If the new health is 0 → OVER. Otherwise → INVULN with counter←COOLDOWN-1.
  - start is ignored in PLAY.
- INVULN: new_hit only disarms; there is no pulse or damage. The counter decrements each cycle. At 0 → PLAY. invuln=1 throughout.
- OVER: game_over=1, health=0. start=1 → reload as in IDLE and go to PLAY.
- Health never underflows. No decrement happens at 0.

## Timing
- All outputs registered. hit_pulse/hit_mask/health change on the edge after the matching inputs are sampled (1-cycle latency).
- hit_pulse is high exactly one cycle. Back-to-back pulses are impossible because INVULN lasts ≥1 cycle.
- An INVULN entered at edge t returns to PLAY at edge t+COOLDOWN. A hit is accepted again from the sample at t+COOLDOWN.
- game_over rises on the same edge health reaches 0.
- rst low mid-game forces IDLE asynchronously. The reset values above apply immediately.
- A start held high across OVER→PLAY does not cause a second reload; the reload occurs only on entering PLAY.

## Configuration
- COLLISION_RANGE_EN defined: match[k] = enemy_valid[k] && enemy_y[k] >= HIT_Y (any enemy at or below the line). armed[k] re-sets only when enemy_y[k] < HIT_Y or the enemy is invalid.
- Undefined: exact equality with HIT_Y as above.

## Test plan
- Reset: rst=0 with random inputs → health=0, game_over=0, hit_pulse=0, invuln=0; release and start=1 → health=3 next cycle.
- Single hit: enemy 1 y=119 valid for 5 cycles in PLAY → one hit_pulse, hit_mask=3'b010, health 3→2, invuln high exactly 16 cycles.
- Simultaneous: enemies 0 and 2 reach 119 on the same cycle → one pulse, hit_mask=3'b101, health decrements by 1.
- Cooldown masking: second enemy hits 5 cycles after first → no pulse, health unchanged. That enemy does not hit later while still parked at 119.
- Game over: three separated hits → health 0, game_over=1. Further hits → no pulse. start=1 → health=3, PLAY.
- Range mode (COLLISION_RANGE_EN): enemy y jumps 118→121 → hit registered. Without the macro → no hit.

Source files
------------

// File: rtl/collision_tracker.sv
// Enemy/hit-line collision detector with player health, post-hit cooldown and game-over flag.
// Optional feature macro COLLISION_RANGE_EN: match on "at or below the line" instead of exact equality.
module collision_tracker #(
  parameter int N_ENEMY    = 3,
  parameter int Y_W        = 8,
  parameter int HIT_Y      = 119,
  parameter int MAX_HEALTH = 3,
  parameter int HP_W       = 4,
  parameter int COOLDOWN   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_ENEMY*Y_W-1:0] enemy_y,
  input  logic [N_ENEMY-1:0]     enemy_valid,
  output logic                   hit_pulse,
  output logic [N_ENEMY-1:0]     hit_mask,
  output logic [HP_W-1:0]        health,
  output logic                   invuln,
  output logic                   game_over,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [Y_W-1:0]   HIT_Y_L  = Y_W'(HIT_Y);
  localparam logic [HP_W-1:0]  HP_MAX_L = HP_W'(MAX_HEALTH);
  localparam logic [CNT_W-1:0] CNT_LD_L = CNT_W'(COOLDOWN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_INVULN, S_OVER} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_ENEMY-1:0] armed;
  logic [N_ENEMY-1:0] match;
  logic [N_ENEMY-1:0] new_hit;

  always_comb begin
    match = '0;
    for (int k = 0; k < N_ENEMY; k++) begin
`ifdef COLLISION_RANGE_EN
      match[k] = enemy_valid[k] && (enemy_y[k*Y_W +: Y_W] >= HIT_Y_L);
`else
      match[k] = enemy_valid[k] && (enemy_y[k*Y_W +: Y_W] == HIT_Y_L);
`endif
    end
  end

  assign new_hit   = match & armed;
  assign dbg_state = state;

  // armed follows ~match every cycle: a matching enemy disarms, leaving the line re-arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      armed     <= '1;
      hit_pulse <= 1'b0;
      hit_mask  <= '0;
      health    <= '0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      armed     <= ~match;
      hit_pulse <= 1'b0;
      hit_mask  <= '0;
      case (state)
        S_IDLE, S_OVER: begin
          if (start) begin
            state     <= S_PLAY;
            health    <= HP_MAX_L;
            armed     <= '1;
            game_over <= 1'b0;
          end
        end
        S_PLAY: begin
          if (|new_hit) begin
            hit_pulse <= 1'b1;
            hit_mask  <= new_hit;
            if (health <= HP_W'(1)) begin
              health    <= '0;
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              health <= health - HP_W'(1);
              state  <= S_INVULN;
              cnt    <= CNT_LD_L;
              invuln <= 1'b1;
            end
          end
        end
        S_INVULN: begin
          if (cnt == '0) begin
            state  <= S_PLAY;
            invuln <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
